serial_half_sub: RTL and testbench

//  Bit-serial subtractor: the inverse operation to the team's combinational half-adder cell.

---
 rtl/serial_half_sub.sv | 130 +++++++++++++
 tb/tb_serial_half_sub.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_half_sub.sv
// serial_half_sub: bit-serial unsigned subtractor, DIFF = A - B, LSB first.
// One difference bit per clock through a registered borrow flop, with a start/done
// handshake. Result and final borrow are registered and held until the next
// completion.
// Build option: define SERIAL_SUB_SAT_EN to clamp diff to 0 whenever a < b
// (saturating subtract). borrow_out still reports the borrow in that case.
module serial_half_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    // Current operand bits and the full-subtractor cell output for this cycle.
    logic bit_x, bit_y, bit_d, br_next;

`ifdef SERIAL_SUB_SAT_EN
    // Saturating finish: an underflowing result is clamped to zero.
    function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] r,
                                                    input logic             bor);
        return bor ? '0 : r;
    endfunction
`endif

    // State register plus datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sha_q    <= '0;
            shb_q    <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sha_q    <= sha_d;
            shb_q    <= shb_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath: capture on accepted start, one bit per RUN cycle.
    always_comb begin
        bit_x    = sha_q[0];
        bit_y    = shb_q[0];
        bit_d    = bit_x ^ bit_y ^ br_q;
        br_next  = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & br_q);

        state_d  = state_q;
        sha_d    = sha_q;
        shb_d    = shb_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sha_d   = a;
                    shb_d   = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sha_d = sha_q >> 1;
                shb_d = shb_q >> 1;
                res_d = {bit_d, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d   = sat_result(res_d, br_next);
`else
                    diff_d   = res_d;
`endif
                    borrow_d = br_next;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_half_sub.sv
// Directed and random checks for serial_half_sub (WIDTH = 8).
module tb_serial_half_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int tests = 0;
    int fails = 0;

    serial_half_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] wrap;
        wrap = x - y;
`ifdef SERIAL_SUB_SAT_EN
        return (x < y) ? '0 : wrap;
`else
        return wrap;
`endif
    endfunction

    // One full operation: start pulse, busy width, done pulse, result, hold.
    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb);
        int cycles;
        logic [W-1:0] ed;
        logic         eb;
        ed = exp_diff(xa, xb);
        eb = (xa < xb);
        a = xa;
        b = xb;
        start = 1'b1;
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            step();
        end
        check({tag, "_busy_w"}, cycles, W);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bor"}, borrow_out, eb);
        step();
        check({tag, "_done_w"}, done, 1'b0);
        check({tag, "_hold"}, diff, ed);
    endtask

    initial begin
        int ndone;
        int bound;
        logic [W-1:0] ra, rb;

        // Reset state
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_bor", borrow_out, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Basic and boundary operands
        run_op("t1", 8'h5A, 8'h3C);
        run_op("t2", 8'h00, 8'h01);
        run_op("t3a", 8'hFF, 8'hFF);
        run_op("t3b", 8'h80, 8'h7F);

        // Start held high: back-to-back ops, operand churn while busy is ignored
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) begin
                ndone++;
                check("t4_diff", diff, 8'h0F);
                check("t4_bor", borrow_out, 1'b0);
            end
            if (busy) begin
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                a = 8'h10;
                b = 8'h01;
            end
        end
        check("t4_ndone", ndone, 2);
        start = 1'b0;
        bound = 0;
        while (!done && bound < 40) begin
            bound++;
            step();
        end
        check("t4_third_done", done, 1'b1);
        check("t4_third_diff", diff, 8'h0F);

        // Reset mid-operation
        step();
        a = 8'hC3;
        b = 8'h5A;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t5_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_diff", diff, 8'h00);
        check("t5_bor", borrow_out, 1'b0);
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) ndone++;
        end
        check("t5_no_done", ndone, 0);
        run_op("t5_after", 8'h09, 8'h03);

        // Random operands against (a - b) mod 256 and (a < b)
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op("rand", ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
